// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit with read-modify-write sub-word stores (optional LSU_MISALIGN_TRAP_EN)
module load_store_unit #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     is_store,
    input  logic [2:0]               funct3,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    output logic                     resp_valid,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     err,
    output logic [ADDRESS_WIDTH-1:0] mem_A,
    output logic [DATA_WIDTH-1:0]    mem_WD,
    output logic                     mem_WE,
    input  logic [DATA_WIDTH-1:0]    mem_RD
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_RMW_RD = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    logic [2:0]               state;
    logic                     st_q;
    logic [2:0]               f3_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [DATA_WIDTH-1:0]    word_q;
    logic [DATA_WIDTH-1:0]    rdata_q;
    logic                     err_q;

    logic                     accept;
    logic                     is_half;
    logic                     is_word;
    logic                     f3_ok;
    logic                     reject;
    logic [ADDRESS_WIDTH-1:0] addr_eff;
    logic [4:0]               lane_shift;
    logic [DATA_WIDTH-1:0]    rd_shifted;
    logic [DATA_WIDTH-1:0]    load_ext;
    logic [DATA_WIDTH-1:0]    lane_mask;
    logic [DATA_WIDTH-1:0]    store_word;

    assign accept  = req_valid && req_ready;
    assign is_half = (funct3[1:0] == 2'b01);
    assign is_word = (funct3[1:0] == 2'b10);

    // Decode legality and effective address of the request being offered
    always_comb begin
        if (is_store)
            f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        else
            f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010)
                 || (funct3 == 3'b100) || (funct3 == 3'b101);
        addr_eff = addr;
`ifdef LSU_MISALIGN_TRAP_EN
        reject = !f3_ok || (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
`else
        reject = !f3_ok;
        if (is_half) addr_eff[0]   = 1'b0;
        if (is_word) addr_eff[1:0] = 2'b00;
`endif
    end

    assign lane_shift = {addr_q[1:0], 3'b000};
    assign rd_shifted = mem_RD >> lane_shift;

    // Extract and extend the addressed byte/halfword of the word read in LOAD
    always_comb begin
        case (f3_q)
            3'b000:  load_ext = {{(DATA_WIDTH-8){rd_shifted[7]}}, rd_shifted[7:0]};
            3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, rd_shifted[7:0]};
            3'b001:  load_ext = {{(DATA_WIDTH-16){rd_shifted[15]}}, rd_shifted[15:0]};
            3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, rd_shifted[15:0]};
            default: load_ext = mem_RD;
        endcase
    end

    // Merge store data into the captured word; full words bypass the merge
    always_comb begin
        if (f3_q[1:0] == 2'b00)
            lane_mask = DATA_WIDTH'(8'hFF) << lane_shift;
        else
            lane_mask = DATA_WIDTH'(16'hFFFF) << lane_shift;
        if (f3_q[1:0] == 2'b10)
            store_word = wdata_q;
        else
            store_word = (word_q & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);
    end

    // Control FSM and request/response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            st_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        st_q    <= is_store;
                        f3_q    <= funct3;
                        addr_q  <= addr_eff;
                        wdata_q <= wdata;
                        rdata_q <= '0;
                        err_q   <= reject;
                        if (reject)       state <= S_RESP;
                        else if (!is_store) state <= S_LOAD;
                        else if (is_word) state <= S_WRITE;
                        else              state <= S_RMW_RD;
                    end
                end
                S_LOAD: begin
                    rdata_q <= load_ext;
                    state   <= S_RESP;
                end
                S_RMW_RD: begin
                    word_q <= mem_RD;
                    state  <= S_WRITE;
                end
                S_WRITE: state <= S_RESP;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign err        = (state == S_RESP) && err_q;
    assign rdata      = (state == S_RESP && !st_q && !err_q) ? rdata_q : '0;
    assign mem_A      = (state == S_LOAD || state == S_RMW_RD || state == S_WRITE)
                        ? {2'b00, addr_q[ADDRESS_WIDTH-1:2]} : '0;
    assign mem_WE     = (state == S_WRITE);
    assign mem_WD     = (state == S_WRITE) ? store_word : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit against a byte-level reference model
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    int          total = 0;
    int          bad = 0;
    int          we_total = 0;
    logic [31:0] we_a;
    logic [31:0] we_d;

    load_store_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata),
        .resp_valid(resp_valid), .rdata(rdata), .err(err),
        .mem_A(mem_a), .mem_WD(mem_wd), .mem_WE(mem_we), .mem_RD(mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[3:0]];

    // Data memory plus a record of every write pulse
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_a[3:0]] <= mem_wd;
            we_total <= we_total + 1;
            we_a <= mem_a;
            we_d <= mem_wd;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int          size;
        int          off;
        int          idx;
        int          cyc;
        int          we0;
        logic        e_err;
        int          e_lat;
        logic [31:0] e_rdata;
        logic [31:0] w;
        logic [7:0]  b [4];
        logic [31:0] aa;

        aa = a;
        size = 1 << (f3 % 4);
        e_err = st ? (f3 > 3'd2) : !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
`ifdef LSU_MISALIGN_TRAP_EN
        if (!e_err && (aa % size) != 0) e_err = 1'b1;
`else
        if (!e_err) aa = aa - (aa % size);
`endif
        idx = int'(aa[5:2]);
        off = int'(aa[1:0]);
        w = ref_mem[idx];
        for (int k = 0; k < 4; k++) b[k] = w[8*k +: 8];
        e_rdata = 32'h0;
        if (e_err) begin
            e_lat = 1;
        end else if (!st) begin
            e_lat = 2;
            for (int k = 0; k < size; k++) e_rdata = e_rdata + (32'(b[off + k]) << (8 * k));
            if (f3 < 3'd4 && size < 4 && e_rdata[8*size-1]) e_rdata = e_rdata - (32'd1 << (8 * size));
        end else begin
            e_lat = (size == 4) ? 2 : 3;
            for (int k = 0; k < size; k++) b[off + k] = wd[8*k +: 8];
            ref_mem[idx] = {b[3], b[2], b[1], b[0]};
        end

        @(negedge clk);
        chk("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        is_store = st;
        funct3 = f3;
        addr = a;
        wdata = wd;
        we0 = we_total;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        is_store = 1'($urandom);
        funct3 = 3'($urandom);
        addr = $urandom;
        wdata = $urandom;
        cyc = 1;
        @(negedge clk);
        while (!resp_valid && cyc < 10) begin
            cyc++;
            @(negedge clk);
        end
        chk("latency", 32'(cyc), 32'(e_lat));
        chk("err", {31'd0, err}, {31'd0, e_err});
        chk("rdata", rdata, e_rdata);
        chk("mem_A_in_resp", mem_a, 32'h0);
        chk("we_pulses", 32'(we_total - we0), (st && !e_err) ? 32'd1 : 32'd0);
        if (st && !e_err) begin
            chk("we_addr", we_a, 32'(idx));
            chk("we_data", we_d, ref_mem[idx]);
        end
        @(negedge clk);
        chk("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        int quiet;
        rst_n = 1'b0;
        req_valid = 1'b0;
        is_store = 1'b0;
        funct3 = 3'b000;
        addr = 32'h0;
        wdata = 32'h0;
        for (int i = 0; i < 16; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[0] = 32'h8899AABB;
        ref_mem[0] = 32'h8899AABB;
        mem[1] = 32'h11223344;
        ref_mem[1] = 32'h11223344;
        #2;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_mem_A", mem_a, 32'h0);
        chk("rst_mem_WD", mem_wd, 32'h0);
        chk("rst_mem_WE", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_req(1'b0, 3'b000, 32'h3, 32'h0);
        do_req(1'b0, 3'b100, 32'h3, 32'h0);
        do_req(1'b1, 3'b001, 32'h6, 32'hDEADBEEF);
        chk("sh_word1", mem[1], 32'hBEEF3344);
        do_req(1'b1, 3'b010, 32'h8, 32'hCAFEF00D);
        do_req(1'b0, 3'b010, 32'h8, 32'h0);
        do_req(1'b0, 3'b011, 32'h4, 32'h0);
        do_req(1'b1, 3'b100, 32'h4, 32'h12345678);
        do_req(1'b0, 3'b010, 32'h2, 32'h0);
        do_req(1'b1, 3'b001, 32'h5, 32'h0000A5A5);
        do_req(1'b0, 3'b101, 32'h7, 32'h0);

        for (int n = 0; n < 200; n++)
            do_req(1'($urandom), 3'($urandom), 32'($urandom_range(0, 63)), $urandom);
        for (int i = 0; i < 16; i++) chk("mem_final", mem[i], ref_mem[i]);

        @(negedge clk);
        req_valid = 1'b1;
        is_store = 1'b1;
        funct3 = 3'b000;
        addr = 32'h11;
        wdata = 32'h000000C3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #3;
        chk("we_in_write", {31'd0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("we_drop_on_reset", {31'd0, mem_we}, 32'd0);
        chk("ready_on_reset", {31'd0, req_ready}, 32'd1);
        chk("resp_on_reset", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid || mem_we) quiet++;
        end
        chk("no_resp_after_reset", 32'(quiet), 32'd0);
        chk("dropped_store_mem", mem[4], ref_mem[4]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
